// File: rtl/instr_loader_pkg.sv
// Shared constants and types for the instruction-memory boot loader.
package instr_loader_pkg;

    // First byte of every load frame.
    localparam logic [7:0] LOAD_SYNC = 8'hA5;

    // Word index width used by fetch: instr_addr[17:2].
    localparam int LOAD_ADDRSIZE = 16;

    // Loader FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5
    } load_state_e;

    // Running frame checksum: plain 8-bit XOR of the data bytes.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs stream bytes MSB-first into one instruction word.
module word_assembler
    import instr_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,      // active-low, synchronous
    input  logic              clear,      // drop any partial word (new frame)
    input  logic              shift_en,   // a data byte is being accepted
    input  logic [7:0]        byte_in,
    output logic              word_full,  // this shift completes a word
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_cnt;

    // The 4th byte of a word is the one accepted while the counter reads 3.
    assign word_full = shift_en && (r_cnt == 2'd3);
    assign word      = r_word;

    // Shift register plus byte-in-word counter; the counter wraps naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else if (shift_en) begin
            r_word <= {r_word[WORD_W-9:0], byte_in};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time writer for the instruction ROM: framed byte stream in,
// word writes out, CPU held in reset until a frame checks out.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = LOAD_ADDRSIZE,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,      // active-low, synchronous
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    load_state_e       r_state, w_state_next;
    logic [7:0]        r_len_hi, w_len_hi_next;
    logic [15:0]       r_remain, w_remain_next;
    logic [ADDR_W-1:0] r_index, w_index_next;
    logic [7:0]        r_chk, w_chk_next;
    logic              r_done, w_done_next;
    logic              r_error, w_error_next;
    logic              r_hold, w_hold_next;
    logic              r_in_ready, r_mem_we, r_busy;

    logic              w_fire;
    logic              w_asm_clear, w_asm_shift, w_word_full;
    logic [15:0]       w_len;
    logic [WORD_W-1:0] w_word;

    assign w_fire = in_valid && r_in_ready;
    assign w_len  = {r_len_hi, in_data};

    word_assembler #(.WORD_W(WORD_W)) u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_asm_clear),
        .shift_en  (w_asm_shift),
        .byte_in   (in_data),
        .word_full (w_word_full),
        .word      (w_word)
    );

    // Next-state and next-value logic for the frame parser.
    always_comb begin
        w_state_next  = r_state;
        w_len_hi_next = r_len_hi;
        w_remain_next = r_remain;
        w_index_next  = r_index;
        w_chk_next    = r_chk;
        w_done_next   = r_done;
        w_error_next  = r_error;
        w_hold_next   = r_hold;
        w_asm_clear   = 1'b0;
        w_asm_shift   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Anything but the sync byte is swallowed silently.
                if (w_fire && in_data == LOAD_SYNC) begin
                    w_done_next  = 1'b0;
                    w_error_next = 1'b0;
                    w_chk_next   = 8'd0;
                    w_index_next = '0;
                    w_hold_next  = 1'b1;
                    w_asm_clear  = 1'b1;
                    w_state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_fire) begin
                    w_len_hi_next = in_data;
                    w_state_next  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_fire) begin
                    // Refuse frames that would run the word index past its range.
                    if (32'(w_len) > (32'd1 << ADDR_W)) begin
                        w_error_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_len == 16'd0) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_remain_next = w_len;
                        w_state_next  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    w_asm_shift = 1'b1;
                    w_chk_next  = chk_update(r_chk, in_data);
                    if (w_word_full) begin
                        w_state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // The write itself is issued by the registered strobe; here we
                // only advance the index and the words-remaining count.
                w_index_next  = r_index + ADDR_W'(1);
                w_remain_next = r_remain - 16'd1;
                w_state_next  = (r_remain > 16'd1) ? ST_DATA : ST_CHECK;
            end
            ST_CHECK: begin
                if (w_fire) begin
                    if (in_data == r_chk) begin
                        w_done_next = 1'b1;
                        w_hold_next = 1'b0;
                    end else begin
                        w_error_next = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, counters, flags and the registered output strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len_hi   <= 8'd0;
            r_remain   <= 16'd0;
            r_index    <= '0;
            r_chk      <= 8'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len_hi   <= w_len_hi_next;
            r_remain   <= w_remain_next;
            r_index    <= w_index_next;
            r_chk      <= w_chk_next;
            r_done     <= w_done_next;
            r_error    <= w_error_next;
            r_hold     <= w_hold_next;
            // Decoded from the upcoming state so the outputs stay pure flops.
            r_in_ready <= (w_state_next != ST_WRITE);
            r_mem_we   <= (w_state_next == ST_WRITE);
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_index;
    assign mem_wdata = w_word;   // assembler register; frozen during WRITE
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign cpu_hold  = r_hold;

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time writer for the instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS words. Each word is written into the instruction ROM array at consecutive word addresses. The CPU is held in reset until a frame completes with a good checksum. It is the write-side counterpart of the fetch path, which reads that array at `instr_addr[17:2]`.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width, matching the fetch index `instr_addr[17:2]`.
- `WORD_W`, 32: instruction width.

Ports:
- `clock`, in, 1: single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-low.
- `in_valid`, in, 1: the source has a byte on `in_data`.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: the loader can accept a byte.
- `mem_we`, out, 1: one-cycle write strobe to the instruction memory.
- `mem_addr`, out, `ADDR_W`: word index for the write.
- `mem_wdata`, out, `WORD_W`: word to write.
- `busy`, out, 1: a frame is in progress (any state other than IDLE).
- `done`, out, 1: sticky flag; the last frame completed and its checksum was good.
- `error`, out, 1: sticky flag; the last frame failed.
- `cpu_hold`, out, 1: drives the core's reset; high means the core is held.

## Operation
- Frame format: sync byte `0xA5`, then LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then CHK.
- CHK must equal the XOR of all 4·N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK.
- IDLE:
  - Bytes other than `0xA5` are accepted and discarded.
  - On `0xA5`: clear `done`, `error` and the byte counter; set `mem_addr`=0 and `cpu_hold`=1; go to LEN_HI.
- LEN_HI → LEN_LO: latch the high byte.
- LEN_LO: latch the low byte, then branch:
  - N > 2^`ADDR_W`: set `error`, go to IDLE.
  - N = 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - Shift each byte into the word register; XOR it into the checksum.
  - After the 4th byte of a word, go to WRITE.
- WRITE (exactly one cycle):
  - `mem_we`=1; `mem_wdata` = assembled word; `mem_addr` = current index.
  - Next cycle: index +1, words-remaining −1.
  - Remaining words > 0: go to DATA, otherwise go to CHECK.
- CHECK: accept one byte.
  - Equal to the checksum: `done`=1, `cpu_hold`=0.
  - Otherwise: `error`=1, `cpu_hold` stays 1.
  - In both cases go to IDLE.
- Words already written before an error are not rolled back.
- A new sync byte in IDLE always starts a new frame, even after `done` (this re-holds the CPU).
- Arithmetic:
  - Word index is `ADDR_W` bits and is never wrapped; the LEN check prevents overflow.
  - Checksum is 8-bit XOR.
  - Byte-in-word counter is 2 bits.

## Timing
- Reset values (active while `reset`=0 at a clock edge):
  - State IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=0, `done`=0, `error`=0, `cpu_hold`=1.
  - Internal counters and checksum = 0.
- A byte transfers on an edge where `in_valid` && `in_ready`.
- `in_ready`=1 in every state except WRITE and except during reset.
- The source may deassert `in_valid` at any cycle. Gaps stall the FSM without losing state.
- `mem_we` rises in the cycle after the edge that accepted byte 4 of a word, and is high for exactly one cycle.
- `mem_addr` and `mem_wdata` are stable while `mem_we`=1.
- Minimum frame time: 4 + 5·N cycles (4·N data-byte cycles plus N WRITE cycles).
- `done`, `error` and `cpu_hold` update on the edge that accepts CHK. For an oversized LEN, `error` updates on the edge that accepts LEN_LO.
- Reset asserted mid-frame: all state returns to reset values on that edge. The partial word is discarded and no `mem_we` is issued.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Structure
- Add to `defines.vh`:
  - `` `LOAD_SYNC`` = 8'hA5.
  - FSM state encodings (3-bit).
  - `` `LOAD_ADDRSIZE`` tied to the existing `` `PCSIZE``-derived word index width.
- Sub-module `word_assembler`:
  - 4-byte shift register with a 2-bit byte counter.
  - Emits `word_full` and the assembled word.
  - Cleared by the FSM on sync and on reset.
- The FSM, counters and checksum live in `instr_loader`.

## Test plan
- Reset held low 3 cycles with `in_valid`=1 → `in_ready`=0, `cpu_hold`=1, all other outputs 0.
- Stream `A5 00 02 12 34 56 78 9A BC DE F0 00` → two `mem_we` pulses: addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0. After CHK: `done`=1, `cpu_hold`=0, `error`=0.
- Same stream with CHK=`01` → both writes occur, then `error`=1, `done`=0, `cpu_hold`=1.
- `00 FF A5 00 00 00` → the leading `00 FF` are ignored; no `mem_we`; `done`=1 after the 6th byte.
- Stream from the 2nd test with random `in_valid` gaps and `in_valid` held high through WRITE → identical writes; no byte is accepted during WRITE cycles.
- Reset low after 6 bytes of the 2nd test's stream → IDLE, `mem_addr`=0, no write. Then a full `A5 00 01 DE AD BE EF 22` writes 0xDEADBEEF at addr 0 and sets `done`=1.
